// File: rtl/letc_core_s1_if.sv
// letc_core_s1_if
// Bundles the stage-1 fetch buses: the hand-off to s2, the branch feedback
// from s2, and the MMU instruction port. The master modport is the fetch
// stage; the slave modport is its environment (s2 and MMU side).
`timescale 1ns/1ps
interface letc_core_s1_if;
  logic [64:0] s1_to_s2;      // {valid, pc[31:0], instr[31:0]}
  logic [32:0] s2_to_s1;      // {branch_taken, branch_target[31:0]}
  logic [32:0] mmu_instr_req; // {valid, addr[31:0]} word-aligned byte address
  logic [32:0] mmu_instr_rsp; // {ready, instr[31:0]} instr meaningful only with ready

  modport master (
    output s1_to_s2,
    output mmu_instr_req,
    input  s2_to_s1,
    input  mmu_instr_rsp
  );

  modport slave (
    input  s1_to_s2,
    input  mmu_instr_req,
    output s2_to_s1,
    output mmu_instr_rsp
  );
endinterface

// File: rtl/letc_core_s1.sv
// letc_core_s1 -- LETC core stage 1 (instruction fetch)
// Holds the PC, issues one word fetch at a time to the MMU, and hands the
// fetched {pc, instr} to s2. Trap and branch redirects squash in-flight work;
// a request already outstanding at the MMU is waited out and its data dropped.
// Optional feature: define LETC_CORE_S1_FETCH_COUNT_EN to add the fetch_count
// output (instructions accepted by s2, wrapping at 2^32).
`timescale 1ns/1ps
module letc_core_s1 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt_req,
  input  logic          s2_busy,
  input  logic [31:0]   trap_target_addr,
  input  logic          trap_occurred,
  letc_core_s1_if.master bus
`ifdef LETC_CORE_S1_FETCH_COUNT_EN
  ,
  output logic [31:0]   fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_OUTPUT  = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    word_align = {addr[31:2], 2'b00};
  endfunction

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [31:0] r_out_pc, w_out_pc_nxt;
  logic [31:0] r_out_instr, w_out_instr_nxt;
  logic        r_req_valid, w_req_valid_nxt;
  logic [31:0] r_req_addr, w_req_addr_nxt;
  logic        r_halt_pend, w_halt_pend_nxt;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_ready;
  logic [31:0] w_rsp_instr;

  // A response only counts while our own request is actually on the bus.
  assign w_ready     = bus.mmu_instr_rsp[32] & r_req_valid;
  assign w_rsp_instr = bus.mmu_instr_rsp[31:0];

  assign bus.s1_to_s2      = {r_out_valid, r_out_pc, r_out_instr};
  assign bus.mmu_instr_req = {r_req_valid, r_req_addr};

  // Redirect selection: trap beats branch; target is forced to a word boundary.
  always_comb begin
    w_redirect = trap_occurred | bus.s2_to_s1[32];
    if (trap_occurred) begin
      w_target = word_align(trap_target_addr);
    end else begin
      w_target = word_align(bus.s2_to_s1[31:0]);
    end
  end

  // Next-state and next-output decode for the fetch FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_out_valid_nxt = r_out_valid;
    w_out_pc_nxt    = r_out_pc;
    w_out_instr_nxt = r_out_instr;
    w_req_valid_nxt = r_req_valid;
    w_req_addr_nxt  = r_req_addr;
    w_halt_pend_nxt = r_halt_pend;
    case (r_state)
      ST_FETCH: begin
        w_halt_pend_nxt = r_halt_pend | halt_req;
        if (w_redirect) begin
          w_pc_nxt        = w_target;
          w_req_valid_nxt = 1'b1;
          if (w_ready || !r_req_valid) begin
            // Nothing left in flight: refetch from the target right away.
            w_state_nxt    = ST_FETCH;
            w_req_addr_nxt = w_target;
          end else begin
            // MMU still owes us a word for the old address; wait it out.
            w_state_nxt    = ST_DISCARD;
            w_req_addr_nxt = r_req_addr;
          end
        end else if (w_ready) begin
          w_out_valid_nxt = 1'b1;
          w_out_pc_nxt    = r_pc;
          w_out_instr_nxt = w_rsp_instr;
          w_pc_nxt        = r_pc + 32'd4;
          w_state_nxt     = ST_OUTPUT;
          w_req_valid_nxt = 1'b0;
        end else begin
          w_req_valid_nxt = 1'b1;
          w_req_addr_nxt  = r_pc;
        end
      end
      ST_DISCARD: begin
        w_halt_pend_nxt = r_halt_pend | halt_req;
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (w_ready) begin
          w_state_nxt     = ST_FETCH;
          w_req_valid_nxt = 1'b1;
          if (w_redirect) begin
            w_req_addr_nxt = w_target;
          end else begin
            w_req_addr_nxt = r_pc;
          end
        end else begin
          w_req_valid_nxt = 1'b1;
          w_req_addr_nxt  = r_req_addr;
        end
      end
      ST_OUTPUT: begin
        w_req_valid_nxt = 1'b0;
        if (w_redirect) begin
          // Held instruction is squashed even if s2 looked ready.
          w_out_valid_nxt = 1'b0;
          w_pc_nxt        = w_target;
          w_state_nxt     = ST_FETCH;
          w_req_valid_nxt = 1'b1;
          w_req_addr_nxt  = w_target;
        end else if (!s2_busy) begin
          w_out_valid_nxt = 1'b0;
          if (halt_req || r_halt_pend) begin
            w_state_nxt     = ST_HALTED;
            w_halt_pend_nxt = 1'b0;
          end else begin
            w_state_nxt     = ST_FETCH;
            w_req_valid_nxt = 1'b1;
            w_req_addr_nxt  = r_pc;
          end
        end else begin
          w_state_nxt = ST_OUTPUT;
        end
      end
      ST_HALTED: begin
        w_req_valid_nxt = 1'b0;
        if (w_redirect) begin
          w_pc_nxt        = w_target;
          w_state_nxt     = ST_FETCH;
          w_req_valid_nxt = 1'b1;
          w_req_addr_nxt  = w_target;
        end else if (!halt_req) begin
          w_state_nxt     = ST_FETCH;
          w_req_valid_nxt = 1'b1;
          w_req_addr_nxt  = r_pc;
        end else begin
          w_state_nxt = ST_HALTED;
        end
      end
      default: begin
        w_state_nxt     = ST_FETCH;
        w_req_valid_nxt = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and registered-output update; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_pc    <= 32'd0;
      r_out_instr <= 32'd0;
      r_req_valid <= 1'b0;
      r_req_addr  <= 32'd0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

`ifdef LETC_CORE_S1_FETCH_COUNT_EN
  logic        w_consume;
  logic [31:0] r_fetch_count;

  assign w_consume   = (r_state == ST_OUTPUT) & r_out_valid & ~s2_busy & ~w_redirect;
  assign fetch_count = r_fetch_count;

  // Count instructions s2 actually accepted; squashed work never gets here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 32'd0;
    end else if (w_consume) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end
`endif

endmodule

// File: tb/tb_letc_core_s1.sv
// tb_letc_core_s1 -- self-checking bench for the LETC stage-1 fetch unit.
// Memory word i holds value i. The reference model tracks only the program
// order s2 must observe: next pc = previous + 4, or the latest redirect target.
`timescale 1ns/1ps
module tb_letc_core_s1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_req;
  logic        s2_busy;
  logic [31:0] trap_target_addr;
  logic        trap_occurred;
`ifdef LETC_CORE_S1_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  letc_core_s1_if bus ();

  letc_core_s1 #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .halt_req         (halt_req),
    .s2_busy          (s2_busy),
    .trap_target_addr (trap_target_addr),
    .trap_occurred    (trap_occurred),
    .bus              (bus)
`ifdef LETC_CORE_S1_FETCH_COUNT_EN
    ,
    .fetch_count      (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        halt;
    logic        rv;
    logic [31:0] ra;
    logic        ov;
    logic [31:0] opc;
    logic [31:0] oins;
  } vec_t;

  vec_t        tbl [15];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_deliv  = 0;
  int          cyc      = 0;
  logic [31:0] exp_pc   = RESET_PC;
  logic [31:0] m_count  = 32'd0;
  int          mmu_cnt  = 0;
  int          mmu_lat  = 1;
  int          lat_min  = 1;
  int          lat_max  = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // MMU model: answers each request after mmu_lat cycles of req.valid, garbage otherwise.
  task automatic mmu_drive();
    if (bus.mmu_instr_req[32] === 1'b1 && !rst) begin
      mmu_cnt++;
      if (mmu_cnt >= mmu_lat) begin
        bus.mmu_instr_rsp = {1'b1, mem_word(bus.mmu_instr_req[31:0])};
        mmu_cnt = 0;
        mmu_lat = $urandom_range(lat_max, lat_min);
      end else begin
        bus.mmu_instr_rsp = {1'b0, 32'($urandom())};
      end
    end else begin
      mmu_cnt = 0;
      bus.mmu_instr_rsp = {1'b0, 32'($urandom())};
    end
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
    mmu_lat = $urandom_range(hi, lo);
  endtask

  // One clock: update the order model from pre-edge values, then check post-edge rules.
  task automatic cycle();
    logic [64:0] pout;
    logic        pv, prv, prdy, prst, redir, cons;
    logic [31:0] ppc, pins, pra, tgt;
    pout  = bus.s1_to_s2;
    pv    = pout[64];
    ppc   = pout[63:32];
    pins  = pout[31:0];
    prv   = bus.mmu_instr_req[32];
    pra   = bus.mmu_instr_req[31:0];
    prdy  = bus.mmu_instr_rsp[32];
    prst  = rst;
    redir = trap_occurred | bus.s2_to_s1[32];
    tgt   = trap_occurred ? trap_target_addr : bus.s2_to_s1[31:0];
    cons  = (pv === 1'b1) && !s2_busy && !redir && !prst;
    if (cons) begin
      chk("deliver_pc", 128'(ppc), 128'(exp_pc));
      chk("deliver_instr", 128'(pins), 128'(mem_word(ppc)));
      exp_pc  = exp_pc + 32'd4;
      m_count = m_count + 32'd1;
      n_deliv++;
    end
    if (prst) begin
      exp_pc  = RESET_PC;
      m_count = 32'd0;
    end else if (redir) begin
      exp_pc = {tgt[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
    if (prst) begin
      chk("reset_out", 128'({bus.s1_to_s2, bus.mmu_instr_req}), 128'd0);
    end else begin
      if (prv === 1'b1 && prdy !== 1'b1)
        chk("req_stable", 128'(bus.mmu_instr_req), 128'({1'b1, pra}));
      if (pv === 1'b1 && s2_busy && !redir)
        chk("busy_hold", 128'({bus.s1_to_s2, bus.mmu_instr_req[32]}), 128'({pout, 1'b0}));
    end
`ifdef LETC_CORE_S1_FETCH_COUNT_EN
    chk("fetch_count", 128'(fetch_count), 128'(m_count));
`endif
    mmu_drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s2_busy = 1'b0;
    halt_req = 1'b0;
    trap_occurred = 1'b0;
    bus.s2_to_s1 = 33'd0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_delivery(input string name, input int budget);
    int s;
    s = n_deliv;
    for (int k = 0; k < budget; k++) begin
      if (n_deliv > s) break;
      cycle();
    end
    chk(name, 128'(n_deliv > s), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [97:0] got, exp;
    int          s;
    rst = 1'b1;
    halt_req = 1'b0;
    s2_busy = 1'b0;
    trap_target_addr = 32'd0;
    trap_occurred = 1'b0;
    bus.s2_to_s1 = 33'd0;
    bus.mmu_instr_rsp = 33'd0;

    // busy halt | req valid/addr | out valid/pc/instr   (1-cycle MMU)
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0,  32'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h8,  1'b0, 32'h0,  32'h0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'hC,  1'b0, 32'h0,  32'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  32'h3};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0,  32'h0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 32'h4};

    // Reset, sequential fetch, busy hold, halt during a fetch and resume.
    set_lat(1, 1);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      s2_busy  = tbl[i].busy;
      halt_req = tbl[i].halt;
      cycle();
      got = {bus.mmu_instr_req[32], bus.mmu_instr_req[32] ? bus.mmu_instr_req[31:0] : 32'h0,
             bus.s1_to_s2[64], bus.s1_to_s2[64] ? bus.s1_to_s2[63:0] : 64'h0};
      exp = {tbl[i].rv, tbl[i].rv ? tbl[i].ra : 32'h0,
             tbl[i].ov, tbl[i].ov ? {tbl[i].opc, tbl[i].oins} : 64'h0};
      chk($sformatf("table_row_%0d", i), 128'(got), 128'(exp));
    end
    halt_req = 1'b0;

    // Branch to 0x100 while the fetch at 0x8 is still outstanding.
    set_lat(3, 3);
    do_reset();
    for (int k = 0; k < 60; k++) begin
      if (bus.mmu_instr_req == {1'b1, 32'h8}) break;
      cycle();
    end
    chk("reach_fetch_8", 128'(bus.mmu_instr_req), 128'({1'b1, 32'h8}));
    bus.s2_to_s1 = {1'b1, 32'h100};
    cycle();
    bus.s2_to_s1 = 33'd0;
    for (int k = 0; k < 20; k++) begin
      if (bus.mmu_instr_req != {1'b1, 32'h8}) break;
      cycle();
    end
    chk("branch_next_addr", 128'(bus.mmu_instr_req), 128'({1'b1, 32'h100}));
    wait_delivery("deliver_after_branch", 40);

    // Trap and branch together: trap target wins.
    set_lat(1, 1);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (bus.s1_to_s2[64] === 1'b1) break;
      cycle();
    end
    chk("reach_output", 128'(bus.s1_to_s2[64]), 128'd1);
    trap_occurred    = 1'b1;
    trap_target_addr = 32'h200;
    bus.s2_to_s1     = {1'b1, 32'h300};
    cycle();
    trap_occurred = 1'b0;
    bus.s2_to_s1  = 33'd0;
    chk("trap_priority", 128'(bus.mmu_instr_req), 128'({1'b1, 32'h200}));
    wait_delivery("deliver_after_trap", 10);

    // Halt, then a trap (unaligned target) wakes the halted core.
    halt_req = 1'b1;
    repeat (8) cycle();
    chk("halted_idle", 128'({bus.mmu_instr_req[32], bus.s1_to_s2[64]}), 128'd0);
    trap_occurred    = 1'b1;
    trap_target_addr = 32'h43;
    cycle();
    trap_occurred = 1'b0;
    chk("trap_wake", 128'(bus.mmu_instr_req), 128'({1'b1, 32'h40}));
    wait_delivery("deliver_after_wake", 10);
    halt_req = 1'b0;

    // Randomized traffic with variable latency and a mid-run reset.
    set_lat(1, 5);
    s = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      s2_busy          = ($urandom_range(9, 0) < 3);
      trap_occurred    = ($urandom_range(49, 0) == 0);
      trap_target_addr = $urandom();
      bus.s2_to_s1     = {($urandom_range(24, 0) == 0), 32'($urandom())};
      if ($urandom_range(39, 0) == 0) halt_req = ~halt_req;
      rst = (i == 1500);
      cycle();
    end
    rst = 1'b0;
    trap_occurred = 1'b0;
    bus.s2_to_s1 = 33'd0;
    halt_req = 1'b0;
    s2_busy = 1'b0;
    chk("random_progress", 128'((n_deliv - s) > 30), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
